// File: rtl/vedic_pkg.sv
// Shared definitions for the time-shared 4x4 Vedic multiplier controller.
//   state_t : sequencing states of the controller
//   OPW     : operand width
//   PRW     : product width
//   ADW     : width of the external shared adder
package vedic_pkg;

  localparam int OPW = 4;
  localparam int PRW = 8;
  localparam int ADW = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/vedic_mul2x2.sv
// Combinational 2x2 Vedic (Urdhva Tiryagbhyam) partial-product unit.
//   x, y : 2-bit unsigned operands
//   p    : 4-bit product x*y
module vedic_mul2x2 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [3:0] p
);

  logic cross_a, cross_b, c1, hi;

  assign cross_a = x[1] & y[0];
  assign cross_b = x[0] & y[1];
  assign c1      = cross_a & cross_b;
  assign hi      = x[1] & y[1];

  assign p[0] = x[0] & y[0];
  assign p[1] = cross_a ^ cross_b;
  assign p[2] = hi ^ c1;
  assign p[3] = hi & c1;

endmodule

// File: rtl/vedic_mul4_seq_ctrl.sv
// Sequencing controller for a time-shared 4x4 Vedic multiplier.
// Four 2x2 partial products are combined over three cycles through one
// external combinational 6-bit adder (add_sum = add_in1 + add_in2).
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b unsigned 4-bit)
//   add_in1/add_in2     : operands driven to the external adder
//   add_sum             : external adder result
//   out_valid/out_ready : product handshake (product = a*b, 8-bit)
//   busy                : controller not idle
module vedic_mul4_seq_ctrl
  import vedic_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [ADW-1:0] add_in1,
  output logic [ADW-1:0] add_in2,
  input  logic [ADW-1:0] add_sum,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PRW-1:0] product,
  output logic           busy
);

  state_t         state, nxt;
  logic [OPW-1:0] a_r, b_r;
  logic [ADW-1:0] t, u;
  logic [3:0]     q0, q1, q2, q3;
  logic [1:0]     q0_lo_in;

  vedic_mul2x2 u_q0 (.x(a_r[1:0]), .y(b_r[1:0]), .p(q0));
  vedic_mul2x2 u_q1 (.x(a_r[3:2]), .y(b_r[1:0]), .p(q1));
  vedic_mul2x2 u_q2 (.x(a_r[1:0]), .y(b_r[3:2]), .p(q2));
  vedic_mul2x2 u_q3 (.x(a_r[3:2]), .y(b_r[3:2]), .p(q3));

  // Low two product bits come straight from the incoming operands so they
  // can be captured at accept time, before a_r/b_r are valid.
  assign q0_lo_in[0] = a[0] & b[0];
  assign q0_lo_in[1] = (a[1] & b[0]) ^ (a[0] & b[1]);

  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_in1   = '0;
    add_in2   = '0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) nxt = S1;
      end
      S1: begin
        add_in1 = {2'b0, q1};
        add_in2 = {2'b0, q2};
        nxt     = S2;
      end
      S2: begin
        add_in1 = t;
        add_in2 = {4'b0, q0[3:2]};
        nxt     = S3;
      end
      S3: begin
        add_in1 = {2'b0, q3};
        add_in2 = {2'b0, u[5:2]};
        nxt     = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      t       <= '0;
      u       <= '0;
      product <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (in_valid) begin
          a_r          <= a;
          b_r          <= b;
          product[1:0] <= q0_lo_in;
        end
        S1: t <= add_sum;
        S2: begin
          u            <= add_sum;
          product[3:2] <= add_sum[1:0];
        end
        S3: begin
          product[7:4] <= add_sum[3:0];
          // u[1:0] already equals product[3:2]; rewriting keeps them tied.
          product[3:2] <= u[1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_mul4_seq_ctrl.sv
module tb_vedic_mul4_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a, b;
  logic [5:0] add_in1, add_in2, add_sum;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // External shared adder, truncated to 6 bits.
  assign add_sum = add_in1 + add_in2;

  vedic_mul4_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .add_in1(add_in1), .add_in2(add_in2), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the block in IDLE. Returns at the negedge where
  // the block is back in IDLE after the output handshake.
  task automatic txn(input logic [3:0] ta, input logic [3:0] tb_, input bit chk_add,
                     input logic [5:0] s1a, input logic [5:0] s1b,
                     input logic [5:0] s2a, input logic [5:0] s2b,
                     input logic [5:0] s3a, input logic [5:0] s3b,
                     input int hold, input bit noise);
    logic [7:0] exp_p;
    exp_p = 8'(ta) * 8'(tb_);
    a = ta; b = tb_; in_valid = 1'b1; out_ready = 1'b0;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_add_in1", add_in1, 0);
    chk("idle_add_in2", add_in2, 0);
    for (int s = 1; s <= 3; s++) begin
      @(negedge clk);
      if (noise) begin
        in_valid = 1'($urandom); a = 4'($urandom); b = 4'($urandom);
      end else in_valid = 1'b0;
      chk("busy_in_ready", in_ready, 0);
      chk("busy_out_valid", out_valid, 0);
      chk("busy_flag", busy, 1);
      if (s == 3) chk("s3_sum_hi_zero", add_sum[5:4], 0);
      if (chk_add) begin
        case (s)
          1: begin chk("s1_add_in1", add_in1, s1a); chk("s1_add_in2", add_in2, s1b); end
          2: begin chk("s2_add_in1", add_in1, s2a); chk("s2_add_in2", add_in2, s2b); end
          default: begin chk("s3_add_in1", add_in1, s3a); chk("s3_add_in2", add_in2, s3b); end
        endcase
      end
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      chk("done_out_valid", out_valid, 1);
      chk("done_product", product, exp_p);
      chk("done_in_ready", in_ready, 0);
      if (h == 0) begin
        chk("done_add_in1", add_in1, 0);
        chk("done_add_in2", add_in2, 0);
      end
      out_ready = (h == hold);
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("post_out_valid", out_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_product_held", product, exp_p);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    chk("rst_busy", busy, 0);
    chk("rst_add_in1", add_in1, 0);
    chk("rst_add_in2", add_in2, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);

    txn(4'd15, 4'd15, 1'b1, 6'd9, 6'd9, 6'd18, 6'd2, 6'd9, 6'd5, 0, 1'b0);
    txn(4'd13, 4'd11, 1'b1, 6'd9, 6'd2, 6'd11, 6'd0, 6'd6, 6'd2, 0, 1'b0);
    txn(4'd0,  4'd0,  1'b1, 6'd0, 6'd0, 6'd0,  6'd0, 6'd0, 6'd0, 0, 1'b0);
    // 1*15: q0=3, q1=0, q2=3, q3=0 -> t=3, u=3, product[3:2]=3
    txn(4'd1,  4'd15, 1'b1, 6'd0, 6'd3, 6'd3,  6'd0, 6'd0, 6'd0, 0, 1'b0);
    txn(4'd7,  4'd9,  1'b0, 6'd0, 6'd0, 6'd0,  6'd0, 6'd0, 6'd0, 10, 1'b0);

    // Reset during S2 aborts the transaction.
    a = 4'd14; b = 4'd14; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;   // S1
    @(negedge clk);                    // S2
    chk("abort_in_s2", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_product", product, 0);
    chk("abort_busy", busy, 0);
    chk("abort_add_in1", add_in1, 0);
    chk("abort_add_in2", add_in2, 0);
    chk("abort_in_ready", in_ready, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_out_valid", out_valid, 0);
      chk("abort_idle_ready", in_ready, 1);
    end
    txn(4'd3, 4'd5, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 0, 1'b0);

    // Exhaustive sweep with random backpressure and junk in_valid while busy.
    for (int i = 0; i < 256; i++)
      txn(4'(i >> 4), 4'(i), 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0,
          int'($urandom_range(0, 2)), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
